sequenciador_registrador7b: RTL and testbench

- Control stage directly upstream of the 7-bit register bank (one flip-flop cell per bit, each with per-bit d, mode select ch1/ch0 and write-enable sinal).
- On a rising edge of a load button, executes one operation: serial load, clear, rotate or parallel load.
- Drives the bank's d bus, mode select and enable, and reads back the bank's q outputs for shift and rotate operations.
- Reports busy/done to the top-level UI.

---
 rtl/sequenciador_registrador7b_pkg.sv | 22 ++
 rtl/sequenciador_registrador7b_if.sv | 25 ++
 rtl/detector_borda.sv | 16 +
 rtl/sequenciador_registrador7b.sv | 123 ++++++++++++
 tb/tb_sequenciador_registrador7b.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/sequenciador_registrador7b_pkg.sv
// Shared definitions for the register-bank sequencer: operation codes,
// bank mode-select constants and the FSM state encoding.
package sequenciador_registrador7b_pkg;

  typedef enum logic [1:0] {
    OP_SERIAL   = 2'b00,
    OP_CLEAR    = 2'b01,
    OP_ROTATE   = 2'b10,
    OP_PARALLEL = 2'b11
  } op_e;

  localparam logic [1:0] CH_LOAD = 2'b00;
  localparam logic [1:0] CH_HOLD = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SHIFT  = 2'b01,
    S_SINGLE = 2'b10,
    S_DONE   = 2'b11
  } state_e;

endpackage

// File: rtl/sequenciador_registrador7b_if.sv
// Control/data bundle between the sequencer, the UI and the 7-bit register bank.
interface sequenciador_registrador7b_if #(
  parameter int unsigned WIDTH = 7
);
  logic             btn_load;
  logic [1:0]       modo;
  logic [WIDTH-1:0] dado_in;
  logic [WIDTH-1:0] regs_q;
  logic [WIDTH-1:0] d;
  logic             ch1;
  logic             ch0;
  logic             sinal;
  logic             busy;
  logic             done;

  modport master (
    output btn_load, modo, dado_in, regs_q,
    input  d, ch1, ch0, sinal, busy, done
  );

  modport slave (
    input  btn_load, modo, dado_in, regs_q,
    output d, ch1, ch0, sinal, busy, done
  );
endinterface

// File: rtl/detector_borda.sv
// Rising-edge detector for a clk-synchronous level; one-cycle pulse per 0->1.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic sinal_i,
  output logic borda_o
);
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= sinal_i;
  end

  assign borda_o = sinal_i & ~prev_q;
endmodule

// File: rtl/sequenciador_registrador7b.sv
// Sequencer for the 7-bit register bank: on a load-button edge runs one
// serial load, clear, rotate or parallel load, with registered outputs.
module sequenciador_registrador7b
  import sequenciador_registrador7b_pkg::*;
#(
  parameter int unsigned WIDTH = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  sequenciador_registrador7b_if.slave  bus
);
  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [1:0]       ch_q, ch_d;
  logic             sinal_q, sinal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             borda;
  logic             start;
  logic [WIDTH-1:0] bank_nx;

  detector_borda u_borda (
    .clk     (clk),
    .rst_n   (rst_n),
    .sinal_i (bus.btn_load),
    .borda_o (borda)
  );

  assign start = borda && (state_q == S_IDLE);

  // regs_q trails the registered d by one write; forward the write landing
  // on this edge so back-to-back shifts build on the bank's true next value.
  assign bank_nx = (sinal_q && (ch_q == CH_LOAD)) ? d_q : bus.regs_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    d_d     = '0;
    ch_d    = CH_HOLD;
    sinal_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          word_d  = bus.dado_in;
          op_d    = op_e'(bus.modo);
          cnt_d   = '0;
          state_d = (op_e'(bus.modo) == OP_SERIAL) ? S_SHIFT : S_SINGLE;
        end
      end
      S_SHIFT: begin
        ch_d    = CH_LOAD;
        sinal_d = 1'b1;
        busy_d  = 1'b1;
        d_d     = {bank_nx[WIDTH-2:0], word_q[LAST - cnt_q]};
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SINGLE: begin
        ch_d    = CH_LOAD;
        sinal_d = 1'b1;
        busy_d  = 1'b1;
        case (op_q)
          OP_CLEAR:  d_d = '0;
          OP_ROTATE: d_d = {bank_nx[WIDTH-2:0], bank_nx[WIDTH-1]};
          default:   d_d = word_q;
        endcase
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_SERIAL;
      cnt_q   <= '0;
      word_q  <= '0;
      d_q     <= '0;
      ch_q    <= CH_HOLD;
      sinal_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      d_q     <= d_d;
      ch_q    <= ch_d;
      sinal_q <= sinal_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.d     = d_q;
  assign bus.ch1   = ch_q[1];
  assign bus.ch0   = ch_q[0];
  assign bus.sinal = sinal_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_sequenciador_registrador7b.sv
// Bench for sequenciador_registrador7b: models the register bank and checks
// every cycle's outputs against an operation-timeline reference model.
module tb_sequenciador_registrador7b;
  localparam int unsigned W = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sequenciador_registrador7b_if #(.WIDTH(W)) bus ();

  sequenciador_registrador7b #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Behavioural register bank fed by the DUT
  logic [W-1:0] bank;
  logic [W-1:0] pre_val = '0;
  logic         pre_en = 1'b0;
  assign bus.regs_q = bank;
  always @(posedge clk) begin
    if (pre_en) bank <= pre_val;
    else if (bus.sinal === 1'b1 && bus.ch1 === 1'b0 && bus.ch0 === 1'b0) bank <= bus.d;
  end

  // Reference model: an accepted operation lives for dur_of() edges;
  // age counts edges since the start edge.
  function automatic int dur_of(input logic [1:0] m);
    return (m == 2'b00) ? int'(W) + 1 : 2;
  endfunction

  logic         prev_m = 1'b0;
  logic         act = 1'b0;
  int           age = 0;
  logic [1:0]   op_m = '0;
  logic [W-1:0] word_m = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      prev_m <= 1'b0;
      act    <= 1'b0;
      age    <= 0;
    end else begin
      prev_m <= bus.btn_load;
      if (bus.btn_load && !prev_m && (!act || age >= dur_of(op_m))) begin
        act    <= 1'b1;
        age    <= 0;
        op_m   <= bus.modo;
        word_m <= bus.dado_in;
      end else if (act) begin
        if (age >= dur_of(op_m)) act <= 1'b0;
        age <= age + 1;
      end
    end
  end

  logic         chk_en = 1'b0;
  int           done_cnt = 0;
  int           wr_cnt = 0;
  logic [W-1:0] e_d;
  logic [1:0]   e_ch;
  logic         e_sinal, e_busy, e_done;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.sinal === 1'b1) wr_cnt++;
    if (chk_en) begin
      e_d = '0; e_ch = 2'b01; e_sinal = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      if (act && age >= 1 && age < dur_of(op_m)) begin
        e_ch = 2'b00; e_sinal = 1'b1; e_busy = 1'b1;
        case (op_m)
          2'b00:   e_d = {bank[W-2:0], word_m[int'(W) - age]};
          2'b01:   e_d = '0;
          2'b10:   e_d = {bank[W-2:0], bank[W-1]};
          default: e_d = word_m;
        endcase
      end else if (act && age == dur_of(op_m)) begin
        e_busy = 1'b1; e_done = 1'b1;
      end
      chk("d", 32'(bus.d), 32'(e_d));
      chk("ch", 32'({bus.ch1, bus.ch0}), 32'(e_ch));
      chk("sinal", 32'(bus.sinal), 32'(e_sinal));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("done", 32'(bus.done), 32'(e_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [W-1:0] v);
    pre_val = v;
    pre_en  = 1'b1;
    tick();
    pre_en  = 1'b0;
  endtask

  // Button held high for the whole operation; modo/dado_in scrambled after start.
  task automatic run_op(input logic [1:0] m, input logic [W-1:0] w,
                        output int lat, output int wr, output int dn);
    int w0, d0;
    w0 = wr_cnt;
    d0 = done_cnt;
    bus.modo = m;
    bus.dado_in = w;
    bus.btn_load = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #2;
      bus.modo = ~m;
      bus.dado_in = ~w;
      @(negedge clk);
      if (bus.done === 1'b1) break;
    end
    if (lat >= 40) chk("done_timeout", 32'(lat), 32'd0);
    bus.btn_load = 1'b0;
    tick();
    wr = wr_cnt - w0;
    dn = done_cnt - d0;
  endtask

  int lat, wr, dn, d0;

  initial begin
    bus.btn_load = 1'b1;
    bus.modo = 2'b00;
    bus.dado_in = '0;
    rst_n = 1'b0;
    pre_val = '0;
    pre_en = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    pre_en = 1'b0;
    chk("rst_ch", 32'({bus.ch1, bus.ch0}), 32'b01);
    chk("rst_sinal", 32'(bus.sinal), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_d", 32'(bus.d), 32'd0);
    bus.btn_load = 1'b0;
    rst_n = 1'b1;
    d0 = done_cnt + wr_cnt;
    repeat (4) tick();
    chk("no_start_after_reset", 32'(done_cnt + wr_cnt - d0), 32'd0);

    preload('0);
    run_op(2'b00, 7'b1011001, lat, wr, dn);
    chk("serial_latency", 32'(lat), 32'd9);
    chk("serial_writes", 32'(wr), 32'd7);
    chk("serial_done_cnt", 32'(dn), 32'd1);
    chk("serial_bank", 32'(bank), 32'b1011001);

    preload(7'b1111111);
    run_op(2'b01, 7'b0101010, lat, wr, dn);
    chk("clear_latency", 32'(lat), 32'd3);
    chk("clear_writes", 32'(wr), 32'd1);
    chk("clear_bank", 32'(bank), 32'd0);

    preload(7'b1000001);
    run_op(2'b10, 7'b0011100, lat, wr, dn);
    chk("rotate1_bank", 32'(bank), 32'b0000011);
    run_op(2'b10, 7'b1111111, lat, wr, dn);
    chk("rotate2_bank", 32'(bank), 32'b0000110);
    chk("rotate_latency", 32'(lat), 32'd3);

    preload('0);
    run_op(2'b11, 7'b0110101, lat, wr, dn);
    chk("parallel_bank", 32'(bank), 32'b0110101);
    chk("parallel_writes", 32'(wr), 32'd1);

    // Second press during a serial load must be ignored
    preload('0);
    d0 = done_cnt;
    bus.modo = 2'b00;
    bus.dado_in = 7'b1011001;
    bus.btn_load = 1'b1;
    tick();
    bus.btn_load = 1'b0;
    tick();
    tick();
    bus.modo = 2'b11;
    bus.dado_in = 7'b1111111;
    bus.btn_load = 1'b1;
    tick();
    bus.btn_load = 1'b0;
    repeat (12) tick();
    chk("busy_press_bank", 32'(bank), 32'b1011001);
    chk("busy_press_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Reset sampled while SHIFT counter is 4: four writes have landed
    preload('0);
    d0 = done_cnt;
    bus.modo = 2'b00;
    bus.dado_in = 7'b1011001;
    bus.btn_load = 1'b1;
    tick();
    bus.btn_load = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_sinal", 32'(bus.sinal), 32'd0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("midrst_bank", 32'(bank), 32'b0001011);
    chk("midrst_done_cnt", 32'(done_cnt - d0), 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
